// File: rtl/sequencer_fsm.sv
// ---------------------------------------------------------------------------
// sequencer_fsm
// Moore instruction sequencer for the relay computer. Fetches each opcode,
// decodes it and drives one strobe set per clock onto the shared 8-bit data
// bus and 16-bit address bus. Owns no data registers.
//
// Ports
//   clock            system clock, rising edge
//   reset            asynchronous, active-high; forces RESET
//   inst[7:0]        Inst register contents (valid from the cycle after FETCH_A)
//   zero/carry/sign  condition flags from the Cond register
//   ld[14:0]         load strobes  (A,B,C,D,M1,M2,X,Y,XY,J1,J2,Inst,PC,INC,Cond)
//   sel[13:0]        bus selects   (A,B,C,D,M1,M2,X,Y,M,XY,J,PC,INC,Imm)
//   MemRead/MemWrite memory strobes
//   AluFunctionCode  ALU op, inst[2:0] during ALU EXEC, else 0
//   Halt             high only in HALTED
//   instDone         one-cycle pulse in the last state of every instruction
// ---------------------------------------------------------------------------
module sequencer_fsm (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  inst,
   input  logic        zero,
   input  logic        carry,
   input  logic        sign,
   output logic [14:0] ld,
   output logic [13:0] sel,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [2:0]  AluFunctionCode,
   output logic        Halt,
   output logic        instDone
);

   // State encodings
   localparam logic [3:0] stateReset  = 4'd0;
   localparam logic [3:0] stateFetchA = 4'd1;
   localparam logic [3:0] stateFetchB = 4'd2;
   localparam logic [3:0] stateExec   = 4'd3;
   localparam logic [3:0] stateG1     = 4'd4;
   localparam logic [3:0] stateG2     = 4'd5;
   localparam logic [3:0] stateG3     = 4'd6;
   localparam logic [3:0] stateG4     = 4'd7;
   localparam logic [3:0] stateG5     = 4'd8;
   localparam logic [3:0] stateG6     = 4'd9;
   localparam logic [3:0] stateHalted = 4'd10;

   // Load strobe bit positions (0..7 are the 8-bit registers A..Y)
   localparam int unsigned ldRegD    = 3;
   localparam int unsigned ldXyBit   = 8;
   localparam int unsigned ldJ1Bit   = 9;
   localparam int unsigned ldJ2Bit   = 10;
   localparam int unsigned ldInstBit = 11;
   localparam int unsigned ldPcBit   = 12;
   localparam int unsigned ldIncBit  = 13;
   localparam int unsigned ldCondBit = 14;

   // Select bit positions (0..7 are the 8-bit registers A..Y)
   localparam int unsigned selMBit   = 8;
   localparam int unsigned selJBit   = 10;
   localparam int unsigned selPcBit  = 11;
   localparam int unsigned selIncBit = 12;
   localparam int unsigned selImmBit = 13;

   localparam logic [7:0] opHalt = 8'hAE;

   logic [3:0] state;
   logic [3:0] nextState;

   // Opcode class decode
   logic isMov, isSetab, isAlu, isLoad, isStore, isHalt, isGoto, isLegalExec;
   logic taken;

   always_comb begin
      isMov       = (inst[7:6] == 2'b00);
      isSetab     = (inst[7:6] == 2'b01);
      isAlu       = (inst[7:4] == 4'b1000);
      isLoad      = (inst[7:2] == 6'b100100);
      isStore     = (inst[7:2] == 6'b100110);
      isHalt      = (inst == opHalt);
      isGoto      = (inst[7:6] == 2'b11) && !inst[0];
      isLegalExec = isMov | isSetab | isAlu | isLoad | isStore | isHalt;
   end

   // Jump condition: any selected flag true, or no condition bits set at all
   always_comb begin
      taken = (inst[4] & sign) | (inst[3] & carry) | (inst[2] & zero) |
              (inst[1] & ~zero) | (inst[4:1] == 4'b0000);
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= stateReset;
      else       state <= nextState;
   end

   // Next-state logic
   always_comb begin
      nextState = state;
      case (state)
         stateReset:  nextState = stateFetchA;
         stateFetchA: nextState = stateFetchB;
         stateFetchB: begin
            if (isGoto)           nextState = stateG1;
            else if (isLegalExec) nextState = stateExec;
            else                  nextState = stateHalted;
         end
         stateExec:   nextState = isHalt ? stateHalted : stateFetchA;
         stateG1:     nextState = stateG2;
         stateG2:     nextState = stateG3;
         stateG3:     nextState = stateG4;
         stateG4:     nextState = stateG5;
         stateG5:     nextState = stateG6;
         stateG6:     nextState = stateFetchA;
         stateHalted: nextState = stateHalted;
         default:     nextState = stateReset;
      endcase
   end

   // Output decode of state and opcode
   always_comb begin
      ld              = '0;
      sel             = '0;
      MemRead         = 1'b0;
      MemWrite        = 1'b0;
      AluFunctionCode = 3'b000;
      Halt            = 1'b0;
      instDone        = 1'b0;
      case (state)
         stateFetchA, stateG1, stateG3: begin
            sel[selPcBit] = 1'b1;
            MemRead       = 1'b1;
            ld[ldIncBit]  = 1'b1;
            if (state == stateFetchA)  ld[ldInstBit] = 1'b1;
            else if (state == stateG1) ld[ldJ1Bit]   = 1'b1;
            else                       ld[ldJ2Bit]   = 1'b1;
         end
         stateFetchB, stateG2, stateG4: begin
            sel[selIncBit] = 1'b1;
            ld[ldPcBit]    = 1'b1;
         end
         stateExec: begin
            instDone = 1'b1;
            if (isMov) begin
               // d==s leaves the data bus undriven, so the destination clears
               ld[inst[5:3]] = 1'b1;
               if (inst[5:3] != inst[2:0]) sel[inst[2:0]] = 1'b1;
            end else if (isSetab) begin
               sel[selImmBit]         = 1'b1;
               ld[{2'b00, inst[5]}]   = 1'b1;
            end else if (isAlu) begin
               AluFunctionCode = inst[2:0];
               ld[ldCondBit]   = 1'b1;
               if (inst[3]) ld[ldRegD] = 1'b1;
               else         ld[0]      = 1'b1;
            end else if (isLoad) begin
               sel[selMBit]         = 1'b1;
               MemRead              = 1'b1;
               ld[{1'b0, inst[1:0]}] = 1'b1;
            end else if (isStore) begin
               sel[selMBit]           = 1'b1;
               sel[{1'b0, inst[1:0]}] = 1'b1;
               MemWrite               = 1'b1;
            end
         end
         stateG5: begin
            // Save return address (PC after operands) when d is set
            if (inst[5]) begin
               sel[selIncBit] = 1'b1;
               ld[ldXyBit]    = 1'b1;
            end
         end
         stateG6: begin
            instDone = 1'b1;
            if (taken) begin
               sel[selJBit] = 1'b1;
               ld[ldPcBit]  = 1'b1;
            end
         end
         stateHalted: Halt = 1'b1;
         default: ;
      endcase
   end

endmodule
